// File: rtl/tc_pkg.sv
// Shared types and constants for the memory-mapped down-counter timer.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] PRESET_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Down-counter timer with IRQ, zero-wait-state bus responder over three register indices.
// Reads are combinational, writes commit on the strobe edge; the bus is never stalled.
module timer_counter
    import tc_pkg::*;
#(
    parameter int BASE_IDX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ADR_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        IRQ
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_pend;

    logic [4:0]  w_rel;
    logic        w_hit;
    logic [1:0]  w_ofs;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_preset;

    logic        w_load;
    logic        w_dec;
    logic        w_set_irq;
    logic        w_clr_irq;
    logic        w_clr_en;

    // Indices below BASE_IDX wrap to large values, so one compare covers both bounds.
    assign w_rel       = {1'b0, ADR_I} - 5'(BASE_IDX);
    assign w_hit       = (w_rel < 5'd3);
    assign w_ofs       = w_rel[1:0];
    assign w_wr        = STB_I & WE_I & w_hit;
    assign w_wr_ctrl   = w_wr & (w_ofs == CTRL_OFS);
    assign w_wr_preset = w_wr & (w_ofs == PRESET_OFS);

    assign ACK_O = STB_I & w_hit;
    assign IRQ   = r_irq_pend & r_im;

    always_comb begin
        DAT_O = 32'd0;
        if (ACK_O) begin
            case (w_ofs)
                CTRL_OFS:   DAT_O = {28'd0, r_im, r_mode, r_en};
                PRESET_OFS: DAT_O = r_preset;
                COUNT_OFS:  DAT_O = r_count;
                default:    DAT_O = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_set_irq   = 1'b0;
        w_clr_irq   = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = CNT;
            end
            CNT: begin
                if (!r_en) begin
                    w_state_nxt = IDLE;
                end else if (r_count == 32'd0) begin
                    w_set_irq   = 1'b1;
                    w_state_nxt = INT;
                end else if (r_count == 32'd1) begin
                    w_dec       = 1'b1;
                    w_set_irq   = 1'b1;
                    w_state_nxt = INT;
                end else begin
                    w_dec = 1'b1;
                end
            end
            INT: begin
                // Modes other than auto-reload fall back to one-shot.
                if (r_mode == MODE_RELOAD) begin
                    w_clr_irq   = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_clr_en    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_mode     <= MODE_ONESHOT;
            r_im       <= 1'b0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_pend <= 1'b0;
        end else begin
            // A same-cycle CTRL write overrides the one-shot EN clear.
            if (w_wr_ctrl) begin
                r_en   <= DAT_I[EN_BIT];
                r_mode <= DAT_I[MODE_MSB:MODE_LSB];
                r_im   <= DAT_I[IM_BIT];
            end else if (w_clr_en) begin
                r_en <= 1'b0;
            end

            if (w_wr_preset) begin
                r_preset <= DAT_I;
            end

            if (w_load) begin
                r_count <= r_preset;
            end else if (w_dec) begin
                r_count <= r_count - 32'd1;
            end

            // Terminal count wins over a bus clear so no interrupt is dropped.
            if (w_set_irq) begin
                r_irq_pend <= 1'b1;
            end else if (w_wr_ctrl | w_wr_preset | w_clr_irq) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter at BASE_IDX=3 (CTRL=3, PRESET=4, COUNT=5).
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ADR_I = 4'd0;
    logic [31:0] DAT_I = 32'd0;
    logic        WE_I = 1'b0;
    logic        STB_I = 1'b0;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] A_CTRL   = 4'd3;
    localparam logic [3:0] A_PRESET = 4'd4;
    localparam logic [3:0] A_COUNT  = 4'd5;

    timer_counter #(.BASE_IDX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .ADR_I (ADR_I),
        .DAT_I (DAT_I),
        .WE_I  (WE_I),
        .STB_I (STB_I),
        .DAT_O (DAT_O),
        .ACK_O (ACK_O),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        ADR_I = a;
        DAT_I = d;
        WE_I  = 1'b1;
        STB_I = 1'b1;
        @(posedge clk);
        #1;
        STB_I = 1'b0;
        WE_I  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic ack);
        ADR_I = a;
        WE_I  = 1'b0;
        STB_I = 1'b1;
        #1;
        d     = DAT_O;
        ack   = ACK_O;
        STB_I = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        ack;
        logic [3:0]  addrs [3] = '{A_CTRL, A_PRESET, A_COUNT};
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            rd(addrs[i], d, ack);
            n_checks++;
            if (d !== 32'd0 || ack !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_reg%0d got dat=%h ack=%b exp dat=0 ack=1", i, d, ack);
            end
        end
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_irq got %b exp 0", IRQ);
        end
        rd(4'd0, d, ack);
        n_checks++;
        if (d !== 32'd0 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_low got dat=%h ack=%b exp dat=0 ack=0", d, ack);
        end
        rd(4'd6, d, ack);
        n_checks++;
        if (d !== 32'd0 || ack !== 1'b0) begin
            n_errors++;
            $display("FAIL miss_high got dat=%h ack=%b exp dat=0 ack=0", d, ack);
        end
        ADR_I = A_CTRL;
        STB_I = 1'b0;
        #1;
        n_checks++;
        if (ACK_O !== 1'b0 || DAT_O !== 32'd0) begin
            n_errors++;
            $display("FAIL no_stb got dat=%h ack=%b exp dat=0 ack=0", DAT_O, ACK_O);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h9);
        step(2);
        for (int i = 0; i < 4; i++) begin
            rd(A_COUNT, d, ack);
            n_checks++;
            if (d !== 32'(3 - i) || IRQ !== (i == 3)) begin
                n_errors++;
                $display("FAIL oneshot_t%0d got cnt=%0d irq=%b exp cnt=%0d irq=%b",
                         i + 2, d, IRQ, 3 - i, (i == 3));
            end
            if (i < 3) step(1);
        end
        step(1);
        rd(A_CTRL, d, ack);
        n_checks++;
        if (d !== 32'h8 || IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL oneshot_ctrl got ctrl=%h irq=%b exp ctrl=8 irq=1", d, IRQ);
        end
        step(3);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL oneshot_hold got cnt=%0d irq=%b exp cnt=0 irq=1", d, IRQ);
        end
        wr(A_CTRL, 32'h8);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_clr got irq=%b exp 0", IRQ);
        end
    endtask

    task automatic test_reload;
        logic [31:0] d;
        logic        ack;
        logic [31:0] exp_cnt [8] = '{2, 1, 0, 0, 2, 1, 0, 0};
        logic        exp_irq [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        step(2);
        for (int i = 0; i < 8; i++) begin
            rd(A_COUNT, d, ack);
            n_checks++;
            if (d !== exp_cnt[i] || IRQ !== exp_irq[i]) begin
                n_errors++;
                $display("FAIL reload_t%0d got cnt=%0d irq=%b exp cnt=%0d irq=%b",
                         i + 2, d, IRQ, exp_cnt[i], exp_irq[i]);
            end
            if (i < 7) step(1);
        end
        wr(A_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_mask;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h1);
        step(3);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_tc got cnt=%0d irq=%b exp cnt=0 irq=0", d, IRQ);
        end
        step(1);
        rd(A_CTRL, d, ack);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++;
            $display("FAIL mask_en_clr got ctrl=%h exp 0", d);
        end
        wr(A_CTRL, 32'h8);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL mask_unmask got irq=%b exp 0", IRQ);
        end
    endtask

    task automatic test_disable;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h1);
        step(6);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd6) begin
            n_errors++;
            $display("FAIL dis_run got cnt=%0d exp 6", d);
        end
        wr(A_CTRL, 32'h0);
        step(3);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd5) begin
            n_errors++;
            $display("FAIL dis_frozen got cnt=%0d exp 5", d);
        end
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd5) begin
            n_errors++;
            $display("FAIL dis_reen_t0 got cnt=%0d exp 5", d);
        end
        step(2);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd10) begin
            n_errors++;
            $display("FAIL dis_reload got cnt=%0d exp 10", d);
        end
        wr(A_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_precedence;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        step(3);
        wr(A_PRESET, 32'd2);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL prec_tc_vs_clr got cnt=%0d irq=%b exp cnt=0 irq=1", d, IRQ);
        end
        wr(A_CTRL, 32'h9);
        rd(A_CTRL, d, ack);
        n_checks++;
        if (d !== 32'h9 || IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL prec_ctrl_vs_en got ctrl=%h irq=%b exp ctrl=9 irq=0", d, IRQ);
        end
        step(2);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd2) begin
            n_errors++;
            $display("FAIL prec_restart got cnt=%0d exp 2", d);
        end
        wr(A_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_corner;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd0);
        wr(A_CTRL, 32'h9);
        step(2);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_t2 got cnt=%h irq=%b exp cnt=0 irq=0", d, IRQ);
        end
        step(1);
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL zero_irq_t3 got irq=%b exp 1", IRQ);
        end
        step(1);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++;
            $display("FAIL zero_nowrap got cnt=%h exp 0", d);
        end
        ADR_I = A_COUNT;
        DAT_I = 32'h1234;
        WE_I  = 1'b1;
        STB_I = 1'b1;
        #1;
        n_checks++;
        if (ACK_O !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt_wr_ack got %b exp 1", ACK_O);
        end
        @(posedge clk);
        #1;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL cnt_wr_ignored got cnt=%h irq=%b exp cnt=0 irq=1", d, IRQ);
        end
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h1);
        step(2);
        wr(A_PRESET, 32'd20);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd4) begin
            n_errors++;
            $display("FAIL preset_mid_cnt got cnt=%0d exp 4", d);
        end
        rd(A_PRESET, d, ack);
        n_checks++;
        if (d !== 32'd20) begin
            n_errors++;
            $display("FAIL preset_mid_rd got preset=%0d exp 20", d);
        end
        step(1);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd3) begin
            n_errors++;
            $display("FAIL preset_mid_next got cnt=%0d exp 3", d);
        end
        wr(A_CTRL, 32'h0);
        step(3);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        ack;
        wr(A_PRESET, 32'd1);
        wr(A_CTRL, 32'h9);
        step(3);
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_pre got irq=%b exp 1", IRQ);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_irq got irq=%b exp 0", IRQ);
        end
        rd(A_CTRL, d, ack);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++;
            $display("FAIL rstmid_ctrl got %h exp 0", d);
        end
        rd(A_PRESET, d, ack);
        n_checks++;
        if (d !== 32'd0) begin
            n_errors++;
            $display("FAIL rstmid_preset got %h exp 0", d);
        end
        step(3);
        rd(A_COUNT, d, ack);
        n_checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_idle got cnt=%h irq=%b exp cnt=0 irq=0", d, IRQ);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_disable();
        test_precedence();
        test_corner();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped down-counter with interrupt, acting as the responder on the bridge's peripheral bus (ADR/DAT/WE/STB/ACK). Three instances occupy timer slots 0–2. Each instance decodes three register indices out of the bridge's 4-bit register index: control, preset and count. Per-instance IRQ goes to the CPU interrupt controller.

## Interface
- BASE_IDX, default 0: first register index claimed by this instance (0, 3 or 6 for timers 0/1/2).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- ADR_I  in  4  register index from bridge; hit when ADR_I ∈ {BASE_IDX, BASE_IDX+1, BASE_IDX+2}.
- DAT_I  in  32  write data.
- WE_I  in  1  1 = write, 0 = read.
- STB_I  in  1  strobe, slot select from bridge.
- DAT_O  out  32  read data; 0 when not acking.
- ACK_O  out  1  combinational, = STB_I & hit.
- IRQ  out  1  interrupt request.

## Operation
- Register map (index − BASE_IDX):
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM (interrupt mask, 1 = enabled); bits 31:4 read 0, writes ignored.
  - 1 PRESET: 32-bit read/write.
  - 2 COUNT: 32-bit read-only; writes are acked and discarded.
- Bus access: word only, no byte enables.
  - Write commits at the edge where STB_I & WE_I & hit.
  - Read is combinational: DAT_O = selected register while ACK_O.
- IRQ = irq_pend & IM (combinational from registers).
- MODE values: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - EN=0 → IDLE, COUNT held.
    - COUNT==0 → INT, no decrement, no wrap.
    - COUNT==1 → COUNT ← 0, irq_pend ← 1, → INT.
    - otherwise COUNT ← COUNT−1.
  - INT, MODE 00: EN ← 0, → IDLE; irq_pend stays 1.
  - INT, MODE 01: irq_pend ← 0, → LOAD (one-cycle IRQ pulse).
- irq_pend clears on any bus write to CTRL or PRESET.
- Precedence and boundary cases:
  - Terminal-count set beats a same-cycle bus clear; the interrupt is not lost.
  - A bus write to CTRL beats the hardware EN clear in INT.
  - A PRESET write during CNT does not touch COUNT; it takes effect at the next LOAD.
  - Clearing EN mid-count freezes COUNT; re-enabling reloads from PRESET via LOAD.
  - A COUNT==0 entry into CNT (PRESET=0) also sets irq_pend when entering INT.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state IDLE. So IRQ=0, and ACK_O/DAT_O follow STB_I (0 when idle).

## Timing
- Bus: zero-wait-state. ACK_O in the same cycle as STB_I; register update at that cycle's closing edge.
- EN written at edge t0 with PRESET=N≥1:
  - LOAD at t1.
  - COUNT=N at t2.
  - COUNT=0, state INT, irq_pend=1 at t0+2+N.
- PRESET=0: INT at t0+3.
- Auto-reload period: N+2 cycles between IRQ pulses (INT→LOAD→CNT…).
- Reset asserted mid-count: all state returns to reset values at that edge; IRQ drops the next cycle.

## Structure
- Package tc_pkg holds:
  - state enum (IDLE/LOAD/CNT/INT);
  - register offsets CTRL_OFS=0, PRESET_OFS=1, COUNT_OFS=2;
  - CTRL bit positions EN_BIT, MODE_LSB/MODE_MSB, IM_BIT;
  - mode constants MODE_ONESHOT, MODE_RELOAD.
- Single module; no sub-module needed. Address decode, register file and FSM live together.

## Test plan
- Reset: after reset, read CTRL/PRESET/COUNT at BASE_IDX=3 (ADR_I=3,4,5) → 0,0,0, IRQ=0; ADR_I=0 with STB_I → ACK_O=0, DAT_O=0.
- One-shot: write PRESET=3, then CTRL=0x9 (EN, IM, MODE 00) at t0 → COUNT reads 3,2,1,0 at t2..t5; IRQ=1 from t5; CTRL reads 0x8; IRQ stays 1 until a CTRL write, then 0.
- Auto-reload: PRESET=2, CTRL=0xB → IRQ one-cycle pulses every 4 cycles; COUNT sequence 2,1,0,0,2,1,0….
- Mask: CTRL=0x1, PRESET=1 → IRQ stays 0; setting IM afterward (write CTRL=0x8) clears irq_pend, so IRQ stays 0.
- Mid-count disable: PRESET=10, run to COUNT=6, write CTRL=0 → COUNT frozen at 6 (or 5 if the decrement edge coincides); re-enable → COUNT reloads to 10.
- Corner: PRESET=0 with EN → IRQ at t0+3, no wrap to 0xFFFFFFFF; a COUNT write is acked with no effect; a PRESET write during CNT leaves COUNT unchanged.
